// File: rtl/uart_rx.sv
// UART receiver: oversamples rxd on bclkx8 ticks, qualifies the start bit and samples
// DBITS data bits (LSB first) plus one stop bit at mid-bit, reporting one-clk status pulses.
module uart_rx #(
    parameter int OVS   = 8,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bclkx8,
    input  logic             rxd,
    input  logic             rdrf,
    output logic [DBITS-1:0] rdr,
    output logic             setrdrf,
    output logic             setoe,
    output logic             setfe
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DBITS + 1);

    typedef enum logic [1:0] {IDLE, START, RECV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    ct1_q, ct1_d;
    logic [BW-1:0]    ct2_q, ct2_d;
    logic [DBITS-1:0] rsr_q, rsr_d;
    logic [DBITS-1:0] rdr_q, rdr_d;
    logic             setrdrf_q, setrdrf_d;
    logic             setoe_q, setoe_d;
    logic             setfe_q, setfe_d;
    logic [1:0]       sync_q;
    logic             bclk_d_q;
    logic             rxs, tick;

    assign rxs  = sync_q[1];
    assign tick = bclkx8 & ~bclk_d_q;

    // Synchroniser resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            bclk_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rxd};
            bclk_d_q <= bclkx8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ct1_q     <= '0;
            ct2_q     <= '0;
            rsr_q     <= '0;
            rdr_q     <= '0;
            setrdrf_q <= 1'b0;
            setoe_q   <= 1'b0;
            setfe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ct1_q     <= ct1_d;
            ct2_q     <= ct2_d;
            rsr_q     <= rsr_d;
            rdr_q     <= rdr_d;
            setrdrf_q <= setrdrf_d;
            setoe_q   <= setoe_d;
            setfe_q   <= setfe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ct1_d     = ct1_q;
        ct2_d     = ct2_q;
        rsr_d     = rsr_q;
        rdr_d     = rdr_q;
        setrdrf_d = 1'b0;
        setoe_d   = 1'b0;
        setfe_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        ct1_d   = '0;
                    end
                end
                START: begin
                    if (rxs) begin
                        state_d = IDLE;
                        ct1_d   = '0;
                    end else if (ct1_q == CW'(OVS/2 - 1)) begin
                        state_d = RECV;
                        ct1_d   = '0;
                        ct2_d   = '0;
                    end else begin
                        ct1_d = ct1_q + 1'b1;
                    end
                end
                RECV: begin
                    if (ct1_q != CW'(OVS - 1)) begin
                        ct1_d = ct1_q + 1'b1;
                    end else if (ct2_q != BW'(DBITS)) begin
                        ct1_d = '0;
                        rsr_d = {rxs, rsr_q[DBITS-1:1]};
                        ct2_d = ct2_q + 1'b1;
                    end else begin
                        // Stop-bit sample: data is delivered even on a framing error
                        rdr_d     = rsr_q;
                        setrdrf_d = 1'b1;
                        setfe_d   = ~rxs;
                        setoe_d   = rdrf;
                        ct1_d     = '0;
                        ct2_d     = '0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rdr     = rdr_q;
    assign setrdrf = setrdrf_q;
    assign setoe   = setoe_q;
    assign setfe   = setfe_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are queued as expectations when sent; a compare process
// matches every status pulse against that queue and checks pulse timing near mid stop bit.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bclkx8 = 1'b0;
    logic       rxd = 1'b1;
    logic       rdrf = 1'b0;
    logic [7:0] rdr;
    logic       setrdrf, setoe, setfe;

    uart_rx #(.OVS(8), .DBITS(8)) dut (
        .clk(clk), .rst(rst), .bclkx8(bclkx8), .rxd(rxd), .rdrf(rdrf),
        .rdr(rdr), .setrdrf(setrdrf), .setoe(setoe), .setfe(setfe)
    );

    always #5 clk = ~clk;

    // bclkx8 toggles every 4 clk -> one tick per 8 clk, bit time 64 clk
    always begin
        repeat (4) @(negedge clk);
        bclkx8 = ~bclkx8;
    end

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       oe;
        int         start;
    } exp_t;

    exp_t       expq[$];
    int         pulse_cyc[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         n_rdrf = 0, n_fe = 0, n_oe = 0;
    logic [7:0] exp_rdr = 8'h00;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Completion must land near mid stop bit: 9.5 bit times (608 clk) after the start edge
    always @(negedge clk) begin
        if (!rst) begin
            if (setrdrf) begin
                n_rdrf++;
                if (setfe) n_fe++;
                if (setoe) n_oe++;
                pulse_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    chk("unexpected_setrdrf", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("rdr_on_pulse", {24'd0, rdr}, {24'd0, e.data});
                    chk("setfe_on_pulse", {31'd0, setfe}, {31'd0, e.fe});
                    chk("setoe_on_pulse", {31'd0, setoe}, {31'd0, e.oe});
                    chk("pulse_in_window", {31'd0, (cyc - e.start >= 600) && (cyc - e.start <= 630)}, 32'd1);
                    exp_rdr = e.data;
                end
            end else begin
                chk("setfe_idle", {31'd0, setfe}, 32'd0);
                chk("setoe_idle", {31'd0, setoe}, 32'd0);
            end
            chk("rdr_hold", {24'd0, rdr}, {24'd0, exp_rdr});
            if (expq.size() > 0 && cyc - expq[0].start > 630) begin
                chk("missing_setrdrf", 32'd0, 32'd1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.data = d; e.fe = ~stop; e.oe = rdrf; e.start = cyc;
        expq.push_back(e);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (64) @(negedge clk);
        end
        rxd = stop;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        exp_rdr = 8'h00;
        #1;
        chk("rst_rdr", {24'd0, rdr}, 32'd0);
        chk("rst_pulses", {29'd0, setrdrf, setoe, setfe}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("init_rdr", {24'd0, rdr}, 32'd0);
        chk("init_pulses", {29'd0, setrdrf, setoe, setfe}, 32'd0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (40) @(negedge clk);

        send_frame(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        chk("lit_rdr_55", {24'd0, rdr}, 32'h55);
        chk("lit_one_pulse", n_rdrf, 32'd1);

        // Glitch: low for two ticks only
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_no_pulse", n_rdrf, 32'd1);
        send_frame(8'h3C, 1'b1);
        repeat (50) @(negedge clk);

        send_frame(8'hA3, 1'b0);
        repeat (50) @(negedge clk);
        chk("lit_fe_count", n_fe, 32'd1);

        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        rdrf = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h0F, 1'b1);
        repeat (20) @(negedge clk);
        chk("lit_rdr_0f", {24'd0, rdr}, 32'h0F);
        chk("lit_oe_count", n_oe, 32'd1);
        rdrf = 1'b0;
        repeat (30) @(negedge clk);

        // Aborted frame 0xF5: reset lands mid data bit 4; remaining bits are all 1
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'hF5 >> i) & 8'h01;
            repeat (64) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        pulse_reset();
        repeat (400) @(negedge clk);
        chk("abort_no_pulse", n_rdrf, 32'd5);
        send_frame(8'hC3, 1'b1);
        repeat (50) @(negedge clk);

        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        repeat (100) @(negedge clk);
        chk("lit_total_pulses", n_rdrf, 32'd8);
        chk("lit_rdr_final", {24'd0, rdr}, 32'h00);
        if (pulse_cyc.size() >= 2)
            chk("b2b_spacing", pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2], 32'd640);
        else
            chk("b2b_pulses_seen", pulse_cyc.size(), 32'd2);
        chk("queue_drained", expq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
